// File: rtl/led_mode_ctrl.sv
// Mode controller for the 4-LED demo: synchronises/debounces the mode switches, sequences
// mode changes through an optional LED blanking window (LED_CTRL_BLANK_EN) and emits restartable ticks.
module led_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_250_000,
`ifdef LED_CTRL_BLANK_EN
    parameter int BLANK_CYCLES    = 12_500_000,
`endif
    parameter int HALF_CYCLES     = 62_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic [1:0] mode,
    output logic       mode_change,
    output logic       led_enable,
    output logic       busy,
    output logic       tick_half,
    output logic       tick_sec
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HALF_W = $clog2(HALF_CYCLES + 1);

`ifdef LED_CTRL_BLANK_EN
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_BLANK = 2'd1, S_COMMIT = 2'd2} state_t;
`else
    typedef enum logic {S_RUN = 1'b0, S_COMMIT = 1'b1} state_t;
`endif

    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_stable;
    logic [DB_W-1:0]   r_db_cnt;
    logic [1:0]        r_mode;
    logic              r_mode_change;
    logic [HALF_W-1:0] r_half_cnt;
    logic              r_sec_phase;
    logic              r_tick_half;
    logic              r_tick_sec;
    state_t            r_state;
    state_t            w_state_next;
    logic              w_commit;

    // Counter tracks how long sync_sw has sat steady at a value other than stable_sw;
    // it restarts on the edge where sync_sw is about to take a new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_stable <= 2'b00;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else if (r_sync1 != r_sync2) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

`ifdef LED_CTRL_BLANK_EN
    logic [BL_W-1:0] r_blank_cnt;
    logic            w_blank_done;

    assign w_blank_done = (r_blank_cnt == BL_W'(BLANK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != S_BLANK) begin
            r_blank_cnt <= '0;
        end else begin
            r_blank_cnt <= r_blank_cnt + BL_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        led_enable   = 1'b1;
        busy         = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (r_stable != r_mode) begin
`ifdef LED_CTRL_BLANK_EN
                    w_state_next = S_BLANK;
`else
                    w_state_next = S_COMMIT;
`endif
                end
            end
`ifdef LED_CTRL_BLANK_EN
            S_BLANK: begin
                led_enable = 1'b0;
                busy       = 1'b1;
                // Switch returned to the committed mode: drop the change silently.
                if (r_stable == r_mode) begin
                    w_state_next = S_RUN;
                end else if (w_blank_done) begin
                    w_state_next = S_COMMIT;
                end
            end
`endif
            S_COMMIT: begin
`ifdef LED_CTRL_BLANK_EN
                led_enable = 1'b0;
`endif
                busy         = 1'b1;
                w_commit     = 1'b1;
                w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    // Timebase is frozen outside RUN and restarts from zero (with tick_sec phase) on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode        <= 2'b00;
            r_mode_change <= 1'b0;
            r_half_cnt    <= '0;
            r_sec_phase   <= 1'b0;
            r_tick_half   <= 1'b0;
            r_tick_sec    <= 1'b0;
        end else begin
            r_mode_change <= w_commit;
            r_tick_half   <= 1'b0;
            r_tick_sec    <= 1'b0;
            if (w_commit) begin
                r_mode      <= r_stable;
                r_half_cnt  <= '0;
                r_sec_phase <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (r_half_cnt == HALF_W'(HALF_CYCLES - 1)) begin
                    r_half_cnt  <= '0;
                    r_tick_half <= 1'b1;
                    r_tick_sec  <= ~r_sec_phase;
                    r_sec_phase <= ~r_sec_phase;
                end else begin
                    r_half_cnt <= r_half_cnt + HALF_W'(1);
                end
            end
        end
    end

    assign mode        = r_mode;
    assign mode_change = r_mode_change;
    assign tick_half   = r_tick_half;
    assign tick_sec    = r_tick_sec;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: per-cycle expected outputs are queued when stimulus
// is driven and compared on the falling edge; works with and without LED_CTRL_BLANK_EN.
module tb_led_mode_ctrl;

    localparam int D = 4;
    localparam int H = 5;
`ifdef LED_CTRL_BLANK_EN
    localparam int   B        = 8;
    localparam logic BLANK_EN = 1'b1;
    localparam int   C_OFF    = D + B + 2;
`else
    localparam logic BLANK_EN = 1'b0;
    localparam int   C_OFF    = D + 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw  = 2'b00;
    logic [1:0] mode;
    logic       mode_change, led_enable, busy, tick_half, tick_sec;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
`ifdef LED_CTRL_BLANK_EN
        .BLANK_CYCLES(B),
`endif
        .HALF_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode), .mode_change(mode_change),
        .led_enable(led_enable), .busy(busy), .tick_half(tick_half), .tick_sec(tick_sec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       mc, le, bz, chk, th, ts;
        string      tag;
    } exp_t;

    typedef struct {
        logic [1:0] sw;
        int         hold;      // 0 = keep until committed, else glitch length in cycles
        logic [1:0] exp_mode;
        string      name;
    } vec_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         anchor;
    logic [1:0] cur_mode;

    function automatic void push_exp(input int c, input logic [1:0] m, input logic mc,
                                     input logic le, input logic bz, input logic chk,
                                     input logic th, input logic ts, input string tag);
        exp_t e;
        e.cyc = c; e.mode = m; e.mc = mc; e.le = le; e.bz = bz;
        e.chk = chk; e.th = th; e.ts = ts; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // RUN cycle: ticks every H cycles after the anchor, tick_sec on odd-numbered ticks.
    function automatic void push_run(input int c, input logic [1:0] m, input logic mc,
                                     input int anc, input string tag);
        int   d;
        logic th;
        d  = c - anc;
        th = (d > 0) && (d % H == 0);
        push_exp(c, m, mc, 1'b1, 1'b0, 1'b1, th, th && ((d / H) % 2 == 1), tag);
    endfunction

    function automatic void push_commit(input int t, input logic [1:0] m0, input logic [1:0] m1,
                                        input int last, input string tag);
        int s_c, c_c, m_c;
        s_c = t + D + 1;
        c_c = t + C_OFF;
        m_c = c_c + 1;
        for (int c = t; c <= last; c++) begin
            if (c <= s_c)
                push_run(c, m0, 1'b0, anchor, tag);
            else if (c <= c_c)
                push_exp(c, m0, 1'b0, ~BLANK_EN, 1'b1, (c >= s_c + 2), 1'b0, 1'b0, tag);
            else
                push_run(c, m1, (c == m_c), m_c, tag);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            ok = (e.cyc == cyc) && (mode === e.mode) && (mode_change === e.mc) &&
                 (led_enable === e.le) && (busy === e.bz) &&
                 (!e.chk || (tick_half === e.th && tick_sec === e.ts));
            if (!ok) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (due %0d): got mode=%b mc=%b le=%b busy=%b th=%b ts=%b, expected mode=%b mc=%b le=%b busy=%b th=%b ts=%b (ticks checked=%b)",
                         e.tag, cyc, e.cyc, mode, mode_change, led_enable, busy, tick_half, tick_sec,
                         e.mode, e.mc, e.le, e.bz, e.th, e.ts, e.chk);
            end
        end
    end

    task automatic advance_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 5000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   t, m_c, last;
        logic [1:0] tgt;

        vecs[0] = '{sw: 2'b10, hold: 0, exp_mode: 2'b10, name: "sw 00->10"};
        vecs[1] = '{sw: 2'b01, hold: 3, exp_mode: 2'b10, name: "glitch 01 x3"};
        vecs[2] = '{sw: 2'b01, hold: 0, exp_mode: 2'b01, name: "sw 10->01"};
        vecs[3] = '{sw: 2'b11, hold: 2, exp_mode: 2'b01, name: "glitch 11 x2"};
        vecs[4] = '{sw: 2'b11, hold: 0, exp_mode: 2'b11, name: "sw 01->11"};
        vecs[5] = '{sw: 2'b00, hold: 0, exp_mode: 2'b00, name: "sw 11->00"};

        for (int c = 1; c <= 3; c++) push_exp(c, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        anchor   = cyc;
        cur_mode = 2'b00;
        for (int c = anchor + 1; c <= anchor + 25; c++) push_run(c, 2'b00, 1'b0, anchor, "idle ticks");
        $display("reset released at cycle %0d", cyc);
        advance_to(anchor + 25);

        for (int i = 0; i < 6; i++) begin
            t  = cyc + 1;
            sw = vecs[i].sw;
            $display("vector %0d '%s' driven, sampled from cycle %0d", i, vecs[i].name, t);
            if (vecs[i].hold == 0) begin
                m_c = t + C_OFF + 1;
                push_commit(t, cur_mode, vecs[i].exp_mode, m_c + 12, vecs[i].name);
                anchor   = m_c;
                cur_mode = vecs[i].exp_mode;
                advance_to(m_c + 12);
            end else begin
                last = t + vecs[i].hold + D + 6;
                for (int c = t; c <= last; c++) push_run(c, vecs[i].exp_mode, 1'b0, anchor, vecs[i].name);
                advance_to(t + vecs[i].hold - 1);
                sw = cur_mode;
                advance_to(last);
            end
        end

`ifdef LED_CTRL_BLANK_EN
        // Abort: switch returns to the committed mode while blanking.
        t  = cyc + 1;
        sw = 2'b11;
        $display("sequence 'abort in BLANK' driven at cycle %0d", t);
        for (int c = t; c <= t + 30; c++) begin
            if (c <= t + 5)       push_run(c, 2'b00, 1'b0, anchor, "abort pre");
            else if (c <= t + 11) push_exp(c, 2'b00, 1'b0, 1'b0, 1'b1, (c >= t + 7), 1'b0, 1'b0, "abort blank");
            else if (c == t + 12) push_exp(c, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort resume");
            else                  push_run(c, 2'b00, 1'b0, anchor + 6, "abort post");
        end
        advance_to(t + 5);
        sw = 2'b00;
        advance_to(t + 30);
        anchor = anchor + 6;

        // Second change while blanking: one commit carrying the newest value.
        t  = cyc + 1;
        sw = 2'b01;
        $display("sequence 'change in BLANK' driven at cycle %0d", t);
        m_c = t + C_OFF + 1;
        push_commit(t, 2'b00, 2'b11, m_c + 12, "change in blank");
        advance_to(t + 5);
        sw = 2'b11;
        advance_to(m_c + 12);
        anchor   = m_c;
        cur_mode = 2'b11;
`endif

        // Reset while a change is in flight.
        t   = cyc + 1;
        tgt = ~cur_mode;
        sw  = tgt;
        $display("sequence 'reset mid-change' driven at cycle %0d", t);
        push_commit(t, cur_mode, tgt, t + 9, "pre reset");
        advance_to(t + 9);
        rst = 1'b1;
        sw  = 2'b00;
        push_exp(t + 10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "reset mid-change");
        anchor = t + 10;
        for (int c = t + 11; c <= t + 30; c++) push_run(c, 2'b00, 1'b0, anchor, "after reset");
        advance_to(t + 10);
        rst = 1'b0;
        advance_to(t + 31);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
